// File: rtl/z80_wait_ctrl_if.sv
// z80_wait_ctrl_if: Z80 bus-side signals seen by the wait-state sequencer
//   cpu_clk   Z80 clock level (sampled in the 24 MHz domain)
//   mreq_n, iorq_n, m1_n, rfsh_n   Z80 bus control strobes
//   tgt       mapper target: 00 ROM, 01 slow RAM, 10 fast RAM, 11 none
//   ws_cfg    [CNT_W-1:0] ROM waits, [2*CNT_W-1:CNT_W] slow-RAM waits
//   stat_clr  clear the wait statistics counter
//   wait_n    to Z80 WAIT, active low
//   busy      sequencer is not idle
//   stat_cnt  total wait cycles inserted
interface z80_wait_ctrl_if #(parameter int CNT_W = 4);
    logic               cpu_clk;
    logic               mreq_n;
    logic               iorq_n;
    logic               m1_n;
    logic               rfsh_n;
    logic [1:0]         tgt;
    logic [2*CNT_W-1:0] ws_cfg;
    logic               stat_clr;
    logic               wait_n;
    logic               busy;
    logic [15:0]        stat_cnt;
    modport master (
        output cpu_clk, mreq_n, iorq_n, m1_n, rfsh_n, tgt, ws_cfg, stat_clr,
        input  wait_n, busy, stat_cnt
    );
    modport slave (
        input  cpu_clk, mreq_n, iorq_n, m1_n, rfsh_n, tgt, ws_cfg, stat_clr,
        output wait_n, busy, stat_cnt
    );
endinterface

// File: rtl/z80_wait_ctrl.sv
// z80_wait_ctrl: Z80 wait-state sequencer stretching ROM, slow-RAM and I/O cycles
//   i_clk_24mhz  system clock, rising edge
//   i_res        synchronous active-high reset
//   bus          z80_wait_ctrl_if.slave (bus strobes, target, config, WAIT_n, BUSY, STAT_CNT)
//   Optional macro WAIT_STATS_EN enables the saturating wait statistics counter.
module z80_wait_ctrl #(
    parameter int IO_WAITS = 1,
    parameter int CNT_W    = 4
) (
    input  logic          i_clk_24mhz,
    input  logic          i_res,
    z80_wait_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    state_t           r_state;
    logic             r_cpu_clk;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wait_n;
    logic             r_busy;
    logic             w_cpu_rise;
    logic             w_mem;
    logic             w_io;
    logic             w_inta;
    logic             w_start;
    logic             w_bus_idle;
    logic [CNT_W-1:0] w_n;
    always_comb begin
        w_cpu_rise = bus.cpu_clk & ~r_cpu_clk;
        w_mem      = ~bus.mreq_n & bus.rfsh_n;
        w_io       = ~bus.iorq_n & bus.m1_n;
        w_inta     = ~bus.iorq_n & ~bus.m1_n;
        w_start    = w_mem | w_io | w_inta;
        w_bus_idle = bus.mreq_n & bus.iorq_n;
        // INTA and fast/unmapped memory fall through to zero waits
        w_n = w_mem ? (bus.tgt == 2'b00 ? bus.ws_cfg[CNT_W-1:0] :
                       bus.tgt == 2'b01 ? bus.ws_cfg[2*CNT_W-1:CNT_W] : '0) :
              w_io  ? CNT_W'(IO_WAITS) : '0;
    end
    always_ff @(posedge i_clk_24mhz) begin
        r_cpu_clk <= bus.cpu_clk;
        if (i_res) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_wait_n <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_busy   <= 1'b1;
                    r_cnt    <= w_n;
                    r_wait_n <= (w_n == '0);
                    r_state  <= (w_n != '0) ? S_WAIT : S_DONE;
                end
                S_WAIT: if (w_bus_idle) begin
                    r_state  <= S_IDLE;
                    r_wait_n <= 1'b1;
                    r_busy   <= 1'b0;
                    r_cnt    <= '0;
                end else if (r_cnt == '0) begin
                    r_state  <= S_DONE;
                    r_wait_n <= 1'b1;
                end else if (w_cpu_rise) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    // release on the same edge the count reaches zero
                    if (r_cnt == CNT_W'(1)) begin
                        r_wait_n <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: if (w_bus_idle) begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_wait_n <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end
    assign bus.wait_n = r_wait_n;
    assign bus.busy   = r_busy;
`ifdef WAIT_STATS_EN
    logic [15:0] r_stat_cnt;
    always_ff @(posedge i_clk_24mhz) begin
        if (i_res || bus.stat_clr)
            r_stat_cnt <= '0;
        else if (w_cpu_rise && !r_wait_n && r_stat_cnt != 16'hFFFF)
            r_stat_cnt <= r_stat_cnt + 16'd1;
    end
    assign bus.stat_cnt = r_stat_cnt;
`else
    logic w_unused_stat_clr;
    assign w_unused_stat_clr = bus.stat_clr;
    assign bus.stat_cnt = 16'h0000;
`endif
endmodule
